// File: rtl/rx_buf_pkg.sv
// Shared defaults, pointer-width helper and occupancy regions for the rx elastic buffer.
// Optional statistics are enabled in the top with RX_ELASTIC_BUF_STATS_EN.
package rx_buf_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_DEPTH       = 16;
    localparam int DEF_HALT_MARGIN = 2;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        NORMAL  = 2'd1,
        HALTING = 2'd2,
        FULL    = 2'd3
    } occ_region_e;

endpackage

// File: rtl/rx_buf_ram.sv
// DEPTH x DATA_W storage array: one synchronous write port, one asynchronous read port.
module rx_buf_ram
    import rx_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ptr_w(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [ptr_w(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]       rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rx_elastic_buf.sv
// Elastic receive FIFO with registered halt, sticky overflow on dropped words and
// an optional saturating drop counter (define RX_ELASTIC_BUF_STATS_EN to add drop_cnt).
module rx_elastic_buf
    import rx_buf_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int HALT_MARGIN = DEF_HALT_MARGIN
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_halt,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ptr_w(DEPTH):0]     level,
    output logic                      overflow,
    input  logic                      clr_overflow
`ifdef RX_ELASTIC_BUF_STATS_EN
    ,
    output logic [15:0]               drop_cnt
`endif
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(DEPTH - HALT_MARGIN);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          halt_q, halt_d;
    logic          ovf_q, ovf_d;
    logic          push, pop, drop;
    occ_region_e   region;

    always_comb begin
        pop      = (count_q != '0) && out_ready;
        // A full buffer still accepts a word when the head leaves on the same edge.
        push     = in_valid && ((count_q < DEPTH_C) || pop);
        drop     = in_valid && (count_q == DEPTH_C) && !pop;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        halt_d   = (count_d >= THRESH_C);
        ovf_d    = drop | (ovf_q & ~clr_overflow);
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            halt_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            halt_q   <= halt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Gating the write with reset keeps the in-flight word of a reset edge out of storage.
    rx_buf_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (pclk),
        .we    (push & presetn),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (out_data)
    );

    assign out_valid = (count_q != '0);
    assign level     = count_q;
    assign in_halt   = halt_q;
    assign overflow  = ovf_q;

`ifdef RX_ELASTIC_BUF_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clr_overflow) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    always_comb begin
        region = NORMAL;
        if (count_q == '0) begin
            region = EMPTY;
        end else if (count_q == DEPTH_C) begin
            region = FULL;
        end else if (count_q >= THRESH_C) begin
            region = HALTING;
        end
    end

    // Halt is computed from count_next, so it always agrees with the settled region.
    always_ff @(posedge pclk) begin
        if (presetn) begin
            assert (halt_q == ((region == HALTING) || (region == FULL)));
        end
    end

endmodule

// File: tb/tb_rx_elastic_buf.sv
// Self-checking bench for rx_elastic_buf: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_rx_elastic_buf;
    import rx_buf_pkg::*;

    localparam int DATA_W      = 8;
    localparam int DEPTH       = 16;
    localparam int HALT_MARGIN = 2;
    localparam int LW          = $clog2(DEPTH) + 1;

    logic              pclk;
    logic              presetn;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_halt;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [LW-1:0]     level;
    logic              overflow;
    logic              clr_overflow;
`ifdef RX_ELASTIC_BUF_STATS_EN
    logic [15:0]       drop_cnt;
`endif

    rx_elastic_buf #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .HALT_MARGIN (HALT_MARGIN)
    ) dut (
        .pclk         (pclk),
        .presetn      (presetn),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_halt      (in_halt),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .level        (level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
`ifdef RX_ELASTIC_BUF_STATS_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO contents as a queue plus flag state.
    logic [DATA_W-1:0] mq[$];
    bit                m_ovf  = 1'b0;
    bit                m_halt = 1'b0;
    int unsigned       m_drops = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit do_pop, do_drop;
        if (!presetn) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_halt  = 1'b0;
            m_drops = 0;
        end else begin
            do_pop  = (mq.size() > 0) && out_ready;
            do_drop = in_valid && (mq.size() == DEPTH) && !do_pop;
            if (do_pop) void'(mq.pop_front());
            if (in_valid && !do_drop) mq.push_back(in_data);
            if (do_drop) m_ovf = 1'b1;
            else if (clr_overflow) m_ovf = 1'b0;
            if (clr_overflow) m_drops = 0;
            else if (do_drop && m_drops < 32'hFFFF) m_drops++;
            m_halt = (mq.size() >= DEPTH - HALT_MARGIN);
        end
    endtask

    task automatic compare_all();
        check("level", 32'(level), 32'(mq.size()));
        check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        check("in_halt", 32'(in_halt), 32'(m_halt));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (mq.size() != 0) check("out_data", 32'(out_data), 32'(mq[0]));
`ifdef RX_ELASTIC_BUF_STATS_EN
        check("drop_cnt", 32'(drop_cnt), m_drops);
`endif
    endtask

    task automatic tick();
        @(posedge pclk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        int sent, popped, cycles;
        bit h_prev, h_now;

        presetn      = 1'b0;
        in_data      = '0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        clr_overflow = 1'b0;
        tick();
        tick();
        check("rst_level", 32'(level), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_halt", 32'(in_halt), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        presetn = 1'b1;
        tick();

        // Pass-through with consumer always ready.
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            in_data   = 8'(8'h11 + i);
            out_ready = 1'b1;
            tick();
            check("pass_data", 32'(out_data), 32'(8'h11 + i));
            check("pass_level_le1", 32'(level <= 1), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("pass_drained", 32'(level), 32'd0);

        // Fill toward the halt threshold.
        out_ready = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
            if (i == 13) check("halt_before_thresh", 32'(in_halt), 32'd0);
        end
        check("halt_at_14", 32'(in_halt), 32'd1);
        check("level_14", 32'(level), 32'd14);

        in_data = 8'd15; tick();
        in_data = 8'd16; tick();
        in_data = 8'hAA; tick();
        check("drop_overflow", 32'(overflow), 32'd1);
        check("drop_level", 32'(level), 32'd16);
        check("drop_head", 32'(out_data), 32'd1);
`ifdef RX_ELASTIC_BUF_STATS_EN
        check("drop_cnt_one", 32'(drop_cnt), 32'd1);
`endif

        in_valid = 1'b0; clr_overflow = 1'b1; tick();
        clr_overflow = 1'b0;
        check("clr_overflow", 32'(overflow), 32'd0);

        in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1; tick();
        check("full_passthru_level", 32'(level), 32'd16);
        check("full_passthru_ovf", 32'(overflow), 32'd0);
        check("full_passthru_head", 32'(out_data), 32'd2);

        out_ready = 1'b0; in_data = 8'hBB; clr_overflow = 1'b1; tick();
        clr_overflow = 1'b0;
        check("drop_and_clr", 32'(overflow), 32'd1);

        in_valid = 1'b0; out_ready = 1'b1;
        repeat (16) tick();
        check("drained_level", 32'(level), 32'd0);
        clr_overflow = 1'b1; out_ready = 1'b0; tick();
        clr_overflow = 1'b0;

        // 40 words from a sender that honours halt one cycle late.
        sent = 0; popped = 0; cycles = 0; h_prev = 1'b0;
        while (sent < 40 && cycles < 2000) begin
            h_now     = in_halt;
            in_valid  = !h_prev && ($urandom_range(3) != 0);
            in_data   = 8'($urandom);
            out_ready = $urandom_range(1) == 1;
            if (in_valid) sent++;
            if (out_valid && out_ready) popped++;
            tick();
            h_prev = h_now;
            cycles++;
        end
        check("rand_sent_budget", 32'(sent), 32'd40);
        in_valid = 1'b0; out_ready = 1'b1; cycles = 0;
        while (level != 0 && cycles < 100) begin
            if (out_valid) popped++;
            tick();
            cycles++;
        end
        check("rand_final_level", 32'(level), 32'd0);
        check("rand_no_overflow", 32'(overflow), 32'd0);
        check("rand_popped", 32'(popped), 32'd40);

        // Reset with content in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h30 + i); tick();
        end
        check("pre_reset_level", 32'(level), 32'd9);
        presetn = 1'b0; in_data = 8'hEE; tick();
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_halt", 32'(in_halt), 32'd0);
        presetn = 1'b1; in_valid = 1'b0; tick();
        check("post_rst_empty", 32'(out_valid), 32'd0);

        // Unconstrained random traffic, including drops and clears.
        for (int c = 0; c < 400; c++) begin
            in_valid     = $urandom_range(3) != 0;
            in_data      = 8'($urandom);
            out_ready    = $urandom_range(1) == 1;
            clr_overflow = $urandom_range(7) == 0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
